// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared constants, instruction-format decode helpers and operand bundle type
package spu_pkg;

    localparam int WIDTH    = 128;
    localparam int NUM_REGS = 128;
    localparam int ADDR_W   = 7;

    typedef enum logic {FMT_RR, FMT_RRR} fmt_e;

    // RRR-form opcodes occupy the four leading instruction bits
    function automatic logic is_rrr(logic [0:31] i);
        logic [0:3] op;
        op = i[0:3];
        return (op == 4'b1000) || (op == 4'b1011) || (op == 4'b1100) ||
               (op == 4'b1101) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

    function automatic fmt_e get_fmt(logic [0:31] i);
        return is_rrr(i) ? FMT_RRR : FMT_RR;
    endfunction

    function automatic logic [ADDR_W-1:0] get_ra(logic [0:31] i);
        return i[18:24];
    endfunction

    function automatic logic [ADDR_W-1:0] get_rb(logic [0:31] i);
        return i[11:17];
    endfunction

    // Non-RRR forms have no RC field; reading register 0 keeps the port quiet
    function automatic logic [ADDR_W-1:0] get_rc(logic [0:31] i, fmt_e fmt);
        return (fmt == FMT_RRR) ? i[25:31] : '0;
    endfunction

    function automatic logic [ADDR_W-1:0] get_rt(logic [0:31] i, fmt_e fmt);
        return (fmt == FMT_RRR) ? i[4:10] : i[25:31];
    endfunction

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] rt;
        logic [WIDTH-1:0]  ra;
        logic [WIDTH-1:0]  rb;
        logic [WIDTH-1:0]  rc;
    } operand_bundle_t;

endpackage

// File: rtl/spu_regfile.sv
// rtl/spu_regfile.sv - 3-read/1-write register file, async reset, no internal bypass
module spu_regfile
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic [ADDR_W-1:0] raddr_c,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [WIDTH-1:0]  rdata_c
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    // Single synchronous write port; reset clears every architected register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/spu_operand_fetch.sv
// rtl/spu_operand_fetch.sv - operand fetch: decode, bypassed register read, registered bundle with stall refresh
module spu_operand_fetch
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instruction,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instruction,
    output logic [ADDR_W-1:0] out_rt_addr,
    output logic [WIDTH-1:0]  RA_data_out,
    output logic [WIDTH-1:0]  RB_data_out,
    output logic [WIDTH-1:0]  RC_data_out
);

    operand_bundle_t   held;
    operand_bundle_t   next_bundle;
    logic              valid_q;
    logic              accept;
    fmt_e              in_fmt;
    fmt_e              held_fmt;
    logic [ADDR_W-1:0] ra_addr, rb_addr, rc_addr;
    logic [ADDR_W-1:0] held_ra, held_rb, held_rc;
    logic [WIDTH-1:0]  ra_rf, rb_rf, rc_rf;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign in_fmt  = get_fmt(in_instruction);
    assign ra_addr = get_ra(in_instruction);
    assign rb_addr = get_rb(in_instruction);
    assign rc_addr = get_rc(in_instruction, in_fmt);

    // Held addresses are re-derived from the stored instruction rather than kept separately
    assign held_fmt = get_fmt(held.instr);
    assign held_ra  = get_ra(held.instr);
    assign held_rb  = get_rb(held.instr);
    assign held_rc  = get_rc(held.instr, held_fmt);

    spu_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (ra_addr),
        .raddr_b (rb_addr),
        .raddr_c (rc_addr),
        .rdata_a (ra_rf),
        .rdata_b (rb_rf),
        .rdata_c (rc_rf)
    );

    // Same-cycle writeback wins over the stale array value on every read port
    always_comb begin
        next_bundle       = '0;
        next_bundle.instr = in_instruction;
        next_bundle.rt    = get_rt(in_instruction, in_fmt);
        next_bundle.ra    = (wb_en && wb_addr == ra_addr) ? wb_data : ra_rf;
        next_bundle.rb    = (wb_en && wb_addr == rb_addr) ? wb_data : rb_rf;
        next_bundle.rc    = (wb_en && wb_addr == rc_addr) ? wb_data : rc_rf;
    end

    // Output register: load on accept, drop on fire, refresh held operands from writeback while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            held    <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            held    <= next_bundle;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q && wb_en) begin
            if (wb_addr == held_ra) begin
                held.ra <= wb_data;
            end
            if (wb_addr == held_rb) begin
                held.rb <= wb_data;
            end
            if (held_fmt == FMT_RRR && wb_addr == held_rc) begin
                held.rc <= wb_data;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_instruction = held.instr;
    assign out_rt_addr     = held.rt;
    assign RA_data_out     = held.ra;
    assign RB_data_out     = held.rb;
    assign RC_data_out     = held.rc;

endmodule

// File: tb/tb_spu_operand_fetch.sv
// tb/tb_spu_operand_fetch.sv - scoreboard bench for spu_operand_fetch against a register-array reference model
module tb_spu_operand_fetch;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_instruction = '0;
    logic         wb_en = 1'b0;
    logic [6:0]   wb_addr = '0;
    logic [127:0] wb_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_instruction;
    logic [6:0]   out_rt_addr;
    logic [127:0] RA_data_out;
    logic [127:0] RB_data_out;
    logic [127:0] RC_data_out;

    spu_operand_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_rt_addr     (out_rt_addr),
        .RA_data_out     (RA_data_out),
        .RB_data_out     (RB_data_out),
        .RC_data_out     (RC_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  instr;
        bit           rrr;
        int           rt, ra, rb, rc;
        logic [127:0] a, b, c;
    } exp_t;

    exp_t         q[$];
    logic [127:0] mregs [128];
    bit           held = 0;
    int           total = 0;
    int           bad = 0;
    int           fired = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Big-endian field [a:b] of a 32-bit instruction word
    function automatic int field(input logic [31:0] w, input int a, input int b);
        return int'((w >> (31 - b)) & ((32'd1 << (b - a + 1)) - 1));
    endfunction

    function automatic logic [127:0] rd(input int addr);
        return (wb_en && int'(wb_addr) == addr) ? wb_data : mregs[addr];
    endfunction

    function automatic logic [31:0] mk_rr(input logic [10:0] op, input logic [6:0] rb, input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    function automatic logic [31:0] mk_rrr(input logic [3:0] op, input logic [6:0] rt, input logic [6:0] rb, input logic [6:0] ra, input logic [6:0] rc);
        return {op, rt, rb, ra, rc};
    endfunction

    // Reference behaviour of one clock edge, evaluated from the inputs presented to that edge
    task automatic model_step();
        bit   fire, acc;
        int   op;
        exp_t e;
        if (reset) return;
        fire = held && out_ready;
        acc  = in_valid && (!held || out_ready);
        if (held && !fire && wb_en && q.size() > 0) begin
            if (q[0].ra == int'(wb_addr)) q[0].a = wb_data;
            if (q[0].rb == int'(wb_addr)) q[0].b = wb_data;
            if (q[0].rrr && q[0].rc == int'(wb_addr)) q[0].c = wb_data;
        end
        if (acc) begin
            op      = field(in_instruction, 0, 3);
            e.instr = in_instruction;
            e.rrr   = (op == 8) || (op >= 11);
            e.rt    = e.rrr ? field(in_instruction, 4, 10) : field(in_instruction, 25, 31);
            e.rb    = field(in_instruction, 11, 17);
            e.ra    = field(in_instruction, 18, 24);
            e.rc    = e.rrr ? field(in_instruction, 25, 31) : 0;
            e.a     = rd(e.ra);
            e.b     = rd(e.rb);
            e.c     = rd(e.rc);
            q.push_back(e);
            held = 1;
        end else if (fire) begin
            held = 0;
        end
        if (wb_en) mregs[wb_addr] = wb_data;
    endtask

    // Drive one cycle of inputs (called at posedge+1), then let the edge happen
    task automatic step(input logic iv, input logic [31:0] ins, input logic we, input logic [6:0] wa,
                        input logic [127:0] wd, input logic ordy);
        in_valid       = iv;
        in_instruction = ins;
        wb_en          = we;
        wb_addr        = wa;
        wb_data        = wd;
        out_ready      = ordy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: checks the presented bundle every cycle and retires it on fire
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("out_valid", {127'b0, out_valid}, {127'b0, q.size() != 0});
            chk("in_ready", {127'b0, in_ready}, {127'b0, (q.size() == 0) || out_ready});
            if (out_valid && q.size() > 0) begin
                e = q[0];
                chk("out_instruction", {96'b0, out_instruction}, {96'b0, e.instr});
                chk("out_rt_addr", {121'b0, out_rt_addr}, 128'(e.rt));
                chk("RA_data_out", RA_data_out, e.a);
                chk("RB_data_out", RB_data_out, e.b);
                if (e.rrr) chk("RC_data_out", RC_data_out, e.c);
                if (out_ready) begin
                    void'(q.pop_front());
                    fired++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [10:0] OP_ROT  = 11'b00001011000;
    localparam logic [10:0] OP_SHL  = 11'b00001011011;
    localparam logic [3:0]  OP_SELB = 4'b1000;

    initial begin
        logic [127:0] d1, d9, d55, rnd;
        logic [3:0]   op4;
        logic [31:0]  ins;
        int           f0;

        d1  = 128'h0123456789ABCDEF0123456789ABCDEF;
        d9  = {8{16'hAAAA}};
        d55 = {8{16'h5555}};
        for (int k = 0; k < 128; k++) mregs[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {127'b0, out_valid}, 128'd0);
        chk("reset RA_data_out", RA_data_out, 128'd0);
        chk("reset out_instruction", {96'b0, out_instruction}, 128'd0);
        reset = 1'b0;
        #1;
        chk("reset in_ready", {127'b0, in_ready}, 128'd1);

        // 1: write r5, accept rot RA=5 RB=6 later
        step(0, '0, 1, 7'd5, d1, 1);
        step(1, mk_rr(OP_ROT, 7'd6, 7'd5, 7'd3), 0, '0, '0, 1);
        step(0, '0, 0, '0, '0, 1);

        // 2: same-cycle wb r9 with RRR selb RA=RB=RC=9
        step(1, mk_rrr(OP_SELB, 7'd17, 7'd9, 7'd9, 7'd9), 1, 7'd9, d9, 1);
        step(0, '0, 0, '0, '0, 1);

        // 3: stall three cycles with RA=12, writeback to r12 on the second
        step(1, mk_rr(OP_ROT, 7'd13, 7'd12, 7'd4), 0, '0, '0, 0);
        step(0, '0, 0, '0, '0, 0);
        step(1, mk_rr(OP_ROT, 7'd1, 7'd2, 7'd3), 1, 7'd12, d55, 0);
        step(1, mk_rr(OP_ROT, 7'd1, 7'd2, 7'd3), 0, '0, '0, 0);
        step(0, '0, 0, '0, '0, 1);
        step(0, '0, 0, '0, '0, 1);

        // 4: eight back-to-back instructions with out_ready held high
        f0 = fired;
        for (int k = 0; k < 8; k++) begin
            step(1, mk_rr(OP_ROT, 7'(k + 1), 7'(k), 7'(k + 20)), (k % 3) == 0, 7'(k), 128'(k * 1001 + 7), 1);
        end
        step(0, '0, 0, '0, '0, 1);
        chk("back_to_back fires", 128'(fired - f0), 128'd8);

        // 6: non-RRR shl with concurrent write to r0
        step(1, mk_rr(OP_SHL, 7'd5, 7'd9, 7'd2), 1, 7'd0, d55, 1);
        step(0, '0, 0, '0, '0, 1);

        // Randomised traffic with a small register window to provoke bypass and refresh hits
        for (int n = 0; n < 400; n++) begin
            op4 = 4'($urandom_range(0, 15));
            if ((op4 == 4'd8) || (op4 >= 4'd11))
                ins = mk_rrr(op4, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 7)),
                             7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
            else
                ins = {op4, 7'($urandom), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom)};
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 1) == 1, 7'($urandom_range(0, 7)),
                 rnd, $urandom_range(0, 2) != 0);
        end

        // 5: reset while a bundle is held
        step(1, mk_rr(OP_ROT, 7'd1, 7'd5, 7'd6), 0, '0, '0, 0);
        chk("pre-reset out_valid", {127'b0, out_valid}, 128'd1);
        reset = 1'b1;
        in_valid = 1'b0;
        wb_en = 1'b0;
        #1;
        chk("mid-reset out_valid", {127'b0, out_valid}, 128'd0);
        chk("mid-reset in_ready", {127'b0, in_ready}, 128'd1);
        chk("mid-reset RA_data_out", RA_data_out, 128'd0);
        q.delete();
        held = 0;
        for (int k = 0; k < 128; k++) mregs[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reads after reset must return zero for previously written registers
        for (int k = 0; k < 8; k++) begin
            step(1, mk_rrr(OP_SELB, 7'd3, 7'(k), 7'(7 - k), 7'(k)), 0, '0, '0, 1);
        end
        for (int n = 0; n < 100; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 1) == 1, mk_rrr(4'd12, 7'($urandom), 7'($urandom_range(0, 3)),
                 7'($urandom_range(0, 3)), 7'($urandom_range(0, 3))),
                 $urandom_range(0, 1) == 1, 7'($urandom_range(0, 3)), rnd, $urandom_range(0, 1) == 1);
        end
        step(0, '0, 0, '0, '0, 1);
        step(0, '0, 0, '0, '0, 1);
        chk("scoreboard drained", 128'(q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
